// File: rtl/logic_op_pkg.sv
// Shared definitions for the logic-op arbiter: op encodings and response FSM states.
package logic_op_pkg;

    localparam logic [1:0] OP_XOR_OR = 2'd0;  // x = (a ^ b) | c
    localparam logic [1:0] OP_OR_XOR = 2'd1;  // x = (a | c) ^ b
    localparam logic [1:0] OP_XOR3   = 2'd2;  // x = a ^ b ^ c
    localparam logic [1:0] OP_PASS   = 2'd3;  // x = a

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational 3-input bitwise logic unit; op selects the evaluation order.
module logic_op_unit
    import logic_op_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [1:0]   op,
    output logic [W-1:0] x
);

    // Evaluate the selected expression bitwise across all W lanes.
    always_comb begin
        x = a;
        case (op)
            OP_XOR_OR: x = (a ^ b) | c;
            OP_OR_XOR: x = (a | c) ^ b;
            OP_XOR3:   x = a ^ b ^ c;
            OP_PASS:   x = a;
            default:   x = a;
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter feeding one shared logic unit; the result is held in a
// single output register and returned on a valid/ready response port.
module logic_op_arbiter
    import logic_op_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [W-1:0] req0_c,
    input  logic [1:0]   req0_op,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [W-1:0] req1_c,
    input  logic [1:0]   req1_op,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_x
);

    state_t       state, state_next;
    logic         last_p1;      // requester granted on the most recent transfer
    logic         grant_p0;
    logic         can_accept;
    logic         xfer_p0;
    logic         consume;

    logic [W-1:0] a_p0, b_p0, c_p0, x_p0;
    logic [1:0]   op_p0;

    logic [W-1:0] x_p1;
    logic         id_p1;

    // Pick the requester: a lone valid one wins, otherwise the one not served last.
    always_comb begin
        grant_p0 = ~last_p1;
        if (req0_valid && !req1_valid) begin
            grant_p0 = 1'b0;
        end else if (!req0_valid && req1_valid) begin
            grant_p0 = 1'b1;
        end
    end

    // Handshake decode; readies depend only on registered state, rsp_ready and the valids.
    always_comb begin
        can_accept = !reset && ((state == EMPTY) || rsp_ready);
        req0_ready = can_accept && !grant_p0;
        req1_ready = can_accept && grant_p0;
        xfer_p0    = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        consume    = (state == FULL) && rsp_ready;
    end

    // Operand mux in front of the single shared logic unit.
    always_comb begin
        a_p0  = grant_p0 ? req1_a  : req0_a;
        b_p0  = grant_p0 ? req1_b  : req0_b;
        c_p0  = grant_p0 ? req1_c  : req0_c;
        op_p0 = grant_p0 ? req1_op : req0_op;
    end

    logic_op_unit #(.W(W)) u_unit (
        .a  (a_p0),
        .b  (b_p0),
        .c  (c_p0),
        .op (op_p0),
        .x  (x_p0)
    );

    // Next state: a transfer always fills the register, a lone consume empties it.
    always_comb begin
        state_next = state;
        if (xfer_p0) begin
            state_next = FULL;
        end else if (consume) begin
            state_next = EMPTY;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // ---- stage p0 -> p1: result register and round-robin pointer ----
    // Load result, tag and pointer on each transfer; pointer starts at 1 so requester 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_p1    <= '0;
            id_p1   <= 1'b0;
            last_p1 <= 1'b1;
        end else if (xfer_p0) begin
            x_p1    <= x_p0;
            id_p1   <= grant_p0;
            last_p1 <= grant_p0;
        end
    end

    assign rsp_valid = (state == FULL);
    assign rsp_x     = x_p1;
    assign rsp_id    = id_p1;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Self-checking bench for logic_op_arbiter: directed scenarios plus random traffic
// checked against a transaction-level reference model.
module tb_logic_op_arbiter;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         req0_valid, req0_ready;
    logic [W-1:0] req0_a, req0_b, req0_c;
    logic [1:0]   req0_op;
    logic         req1_valid, req1_ready;
    logic [W-1:0] req1_a, req1_b, req1_c;
    logic [1:0]   req1_op;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_x;

    logic_op_arbiter #(.W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_c     (req0_c),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_c     (req1_c),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_x      (rsp_x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model: result register contents and who was served last
    logic         m_full;
    logic [W-1:0] m_x;
    logic         m_id;
    logic         m_last;
    logic         obs_g0, obs_g1;

    function automatic logic [W-1:0] eval(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [W-1:0] c);
        logic [W-1:0] r;
        if (op == 2'd0)      r = (a ^ b) | c;
        else if (op == 2'd1) r = (a | c) ^ b;
        else if (op == 2'd2) r = a ^ b ^ c;
        else                 r = a;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_x    = '0;
        m_id   = 1'b0;
        m_last = 1'b1;
    endtask

    task automatic drive_req(input int n, input logic v, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] c, input logic [1:0] op);
        if (n == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_c = c; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_c = c; req1_op = op;
        end
    endtask

    // One clock cycle: check readies before the edge, advance the model, check response after.
    task automatic step();
        logic can, e0, e1;
        #1;
        can = !m_full || rsp_ready;
        chk("ready_excl", {31'd0, req0_ready & req1_ready}, 32'd0);
        e0 = 1'b0;
        e1 = 1'b0;
        if (req0_valid) begin
            e0 = can && (!req1_valid || m_last);
            chk("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
        end
        if (req1_valid) begin
            e1 = can && (!req0_valid || !m_last);
            chk("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
        end
        obs_g0 = req0_valid && req0_ready;
        obs_g1 = req1_valid && req1_ready;
        @(posedge clk);
        if (e0) begin
            m_full = 1'b1; m_x = eval(req0_op, req0_a, req0_b, req0_c); m_id = 1'b0; m_last = 1'b0;
        end else if (e1) begin
            m_full = 1'b1; m_x = eval(req1_op, req1_a, req1_b, req1_c); m_id = 1'b1; m_last = 1'b1;
        end else if (m_full && rsp_ready) begin
            m_full = 1'b0;
        end
        #1;
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_full});
        if (m_full) begin
            chk("rsp_x", {24'd0, rsp_x}, {24'd0, m_x});
            chk("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
        end
        @(negedge clk);
    endtask

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_g[4];
        exp_g = '{0, 1, 0, 1};

        reset = 1'b1;
        rsp_ready = 1'b1;
        drive_req(0, 1'b1, 8'h0F, 8'h3C, 8'h80, 2'd0);
        drive_req(1, 1'b1, 8'h11, 8'h22, 8'h33, 2'd2);
        model_reset();
        #2;
        // reset state, readies gated even with valid requests and rsp_ready high
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_x", {24'd0, rsp_x}, 32'd0);
        chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive_req(1, 1'b0, '0, '0, '0, 2'd0);

        // single requester, each op with fixed operands
        drive_req(0, 1'b1, 8'h0F, 8'h3C, 8'h80, 2'd0);
        step(); chk("op0_x", {24'd0, rsp_x}, 32'hB3); chk("op0_g", {31'd0, obs_g0}, 32'd1);
        drive_req(0, 1'b1, 8'h0F, 8'h3C, 8'h80, 2'd1);
        step(); chk("op1_x", {24'd0, rsp_x}, 32'hB3);
        drive_req(0, 1'b1, 8'h0F, 8'h3C, 8'h80, 2'd2);
        step(); chk("op2_x", {24'd0, rsp_x}, 32'hB3);
        drive_req(0, 1'b1, 8'h0F, 8'h3C, 8'h80, 2'd3);
        step(); chk("op3_x", {24'd0, rsp_x}, 32'h0F);

        // drain
        drive_req(0, 1'b0, '0, '0, '0, 2'd0);
        step(); chk("drain_valid", {31'd0, rsp_valid}, 32'd0);

        // contention straight after reset: grants alternate starting with requester 0
        reset = 1'b1; #1; model_reset(); @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_req(0, 1'b1, 8'(i), 8'hF0, 8'h01, 2'd2);
            drive_req(1, 1'b1, 8'(i + 8), 8'h0F, 8'h02, 2'd0);
            step();
            chk("cont_grant0", {31'd0, obs_g0}, {31'd0, exp_g[i] == 0});
            chk("cont_grant1", {31'd0, obs_g1}, {31'd0, exp_g[i] == 1});
            chk("cont_rsp_id", {31'd0, rsp_id}, exp_g[i]);
        end
        drive_req(0, 1'b0, '0, '0, '0, 2'd0);
        drive_req(1, 1'b0, '0, '0, '0, 2'd0);
        step();

        // backpressure: held result, requester 1 waits, no bubble on release
        drive_req(0, 1'b1, 8'h55, 8'hAA, 8'h00, 2'd2);
        step();
        drive_req(0, 1'b0, '0, '0, '0, 2'd0);
        drive_req(1, 1'b1, 8'h12, 8'h34, 8'h56, 2'd1);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
            step();
            chk("bp_hold_x", {24'd0, rsp_x}, 32'hFF);
            chk("bp_hold_id", {31'd0, rsp_id}, 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, req1_ready}, 32'd1);
        step();
        chk("bp_new_valid", {31'd0, rsp_valid}, 32'd1);
        chk("bp_new_id", {31'd0, rsp_id}, 32'd1);
        chk("bp_new_x", {24'd0, rsp_x}, {24'd0, (8'h12 | 8'h56) ^ 8'h34});
        drive_req(1, 1'b0, '0, '0, '0, 2'd0);
        step();

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive_req(0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
                      2'($urandom_range(0, 3)));
            drive_req(1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
                      2'($urandom_range(0, 3)));
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // reset mid-operation while holding a result under backpressure
        drive_req(0, 1'b1, 8'hC3, 8'h00, 8'h00, 2'd3);
        drive_req(1, 1'b0, '0, '0, '0, 2'd0);
        rsp_ready = 1'b1;
        step();
        drive_req(0, 1'b0, '0, '0, '0, 2'd0);
        rsp_ready = 1'b0;
        #2;
        chk("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
        reset = 1'b1;
        #1;
        model_reset();
        chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_x", {24'd0, rsp_x}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rsp_ready = 1'b1;
        drive_req(0, 1'b1, 8'h01, 8'h02, 8'h04, 2'd2);
        drive_req(1, 1'b1, 8'h10, 8'h20, 8'h40, 2'd2);
        step();
        chk("postrst_grant0", {31'd0, obs_g0}, 32'd1);
        chk("postrst_x", {24'd0, rsp_x}, 32'h07);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
